// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye object path: DMA state encoding and the
// object-table geometry used by both the DMA engine and the object line engine.
package jtpopeye_pkg;

  // DMA engine states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_REL  = 3'd4
  } dma_st_t;

  // Object attribute table location in CPU space and its size (40 objects x 4 bytes)
  localparam logic [15:0] OBJ_SRC_BASE    = 16'h8C04;
  localparam int          OBJ_BYTES_DEF   = 160;
  // Pixel ticks to wait for the CPU to grant the bus
  localparam int          REQ_TIMEOUT_DEF = 255;

  // CPU read address for a table index; wraps at 16 bits
  function automatic logic [15:0] obj_src_addr(input logic [15:0] base, input logic [7:0] idx);
    return base + {8'd0, idx};
  endfunction

endpackage

// File: rtl/jtpopeye_obj_dma.sv
// Object DMA engine. On the rising edge of VB it requests the CPU bus, copies
// OBJ_BYTES bytes from CPU RAM at SRC_BASE into object RAM, then releases the
// bus. Everything advances on pxl_cen; all outputs are registered.
// Optional feature macro: JTPOPEYE_DBLBUF_EN
//   defined   : two object RAM banks; the copy fills the hidden bank and the
//               banks swap on a successful transfer.
//   undefined : single bank (obj_bank stays 0, obj_addr[8] stays 0); an abort
//               leaves a partially updated table.
module jtpopeye_obj_dma
  import jtpopeye_pkg::*;
#(
  parameter logic [15:0] SRC_BASE    = OBJ_SRC_BASE,
  parameter int          OBJ_BYTES   = OBJ_BYTES_DEF,
  parameter int          REQ_TIMEOUT = REQ_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        VB,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_din,
  output logic [8:0]  obj_addr,
  output logic [7:0]  obj_dout,
  output logic        obj_we,
  output logic        obj_bank,
  output logic        dma_busy
);

  localparam logic [7:0]  LAST_IDX  = 8'(OBJ_BYTES - 1);
  localparam logic [15:0] TMO_LIMIT = 16'(REQ_TIMEOUT);

  dma_st_t     state_reg,    state_next;
  logic [7:0]  idx_reg,      idx_next;
  logic [15:0] tmo_reg,      tmo_next;
  logic        vb_last_reg,  vb_last_next;
  logic        abort_reg,    abort_next;
  logic        busrq_n_reg,  busrq_n_next;
  logic [15:0] src_addr_reg, src_addr_next;
  logic [8:0]  obj_addr_reg, obj_addr_next;
  logic [7:0]  obj_dout_reg, obj_dout_next;
  logic        obj_we_reg,   obj_we_next;
  logic        obj_bank_reg, obj_bank_next;
  logic        dma_busy_reg, dma_busy_next;

  logic        vb_rise;
  logic        vb_fall;
  logic [15:0] tmo_inc;
  logic        wr_bank;

  assign vb_rise = VB & ~vb_last_reg;
  assign vb_fall = ~VB & vb_last_reg;
  assign tmo_inc = tmo_reg + 16'd1;

`ifdef JTPOPEYE_DBLBUF_EN
  // Fill the bank the display is not reading
  assign wr_bank = ~obj_bank_reg;
`else
  // Single bank: writes land in the displayed table
  assign wr_bank = 1'b0;
`endif

  // Next-state and next-output logic; applied only on pxl_cen ticks
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    tmo_next      = tmo_reg;
    vb_last_next  = VB;
    abort_next    = abort_reg;
    busrq_n_next  = busrq_n_reg;
    src_addr_next = src_addr_reg;
    obj_addr_next = obj_addr_reg;
    obj_dout_next = obj_dout_reg;
    obj_we_next   = 1'b0;
    obj_bank_next = obj_bank_reg;

    case (state_reg)
      ST_IDLE: begin
        // Only a fresh VB edge starts a frame; a VB still high after a
        // transfer does not retrigger
        if (vb_rise) begin
          state_next   = ST_REQ;
          busrq_n_next = 1'b0;
          tmo_next     = 16'd0;
        end
      end

      ST_REQ: begin
        if (vb_fall) begin
          state_next = ST_REL;
          abort_next = 1'b1;
        end else if (!busak_n) begin
          state_next    = ST_RD;
          idx_next      = 8'd0;
          src_addr_next = obj_src_addr(SRC_BASE, 8'd0);
        end else begin
          tmo_next = tmo_inc;
          if (tmo_inc >= TMO_LIMIT) begin
            state_next = ST_REL;
            abort_next = 1'b1;
          end
        end
      end

      ST_RD: begin
        // Address is already on the bus; this tick lets CPU RAM return data
        if (vb_fall || busak_n) begin
          state_next = ST_REL;
          abort_next = 1'b1;
        end else begin
          state_next = ST_WR;
        end
      end

      ST_WR: begin
        // An abort here suppresses the write of the current byte
        if (vb_fall || busak_n) begin
          state_next = ST_REL;
          abort_next = 1'b1;
        end else begin
          obj_we_next   = 1'b1;
          obj_dout_next = src_din;
          obj_addr_next = {wr_bank, idx_reg};
          if (idx_reg == LAST_IDX) begin
            state_next = ST_REL;
          end else begin
            idx_next      = idx_reg + 8'd1;
            src_addr_next = obj_src_addr(SRC_BASE, idx_reg + 8'd1);
            state_next    = ST_RD;
          end
        end
      end

      ST_REL: begin
        busrq_n_next = 1'b1;
`ifdef JTPOPEYE_DBLBUF_EN
        // Only a complete table becomes visible
        if (!abort_reg) begin
          obj_bank_next = ~obj_bank_reg;
        end
`endif
        abort_next = 1'b0;
        state_next = ST_IDLE;
      end

      default: begin
        state_next   = ST_IDLE;
        busrq_n_next = 1'b1;
        abort_next   = 1'b0;
      end
    endcase

    dma_busy_next = (state_next != ST_IDLE);
  end

  // State and output registers; reset takes effect regardless of pxl_cen
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= 8'd0;
      tmo_reg      <= 16'd0;
      // Treat reset as if VB was already seen high, so coming out of reset
      // mid-blank does not start a partial-frame transfer
      vb_last_reg  <= 1'b1;
      abort_reg    <= 1'b0;
      busrq_n_reg  <= 1'b1;
      src_addr_reg <= SRC_BASE;
      obj_addr_reg <= 9'd0;
      obj_dout_reg <= 8'd0;
      obj_we_reg   <= 1'b0;
      obj_bank_reg <= 1'b0;
      dma_busy_reg <= 1'b0;
    end else if (pxl_cen) begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      tmo_reg      <= tmo_next;
      vb_last_reg  <= vb_last_next;
      abort_reg    <= abort_next;
      busrq_n_reg  <= busrq_n_next;
      src_addr_reg <= src_addr_next;
      obj_addr_reg <= obj_addr_next;
      obj_dout_reg <= obj_dout_next;
      obj_we_reg   <= obj_we_next;
      obj_bank_reg <= obj_bank_next;
      dma_busy_reg <= dma_busy_next;
    end
  end

  assign busrq_n  = busrq_n_reg;
  assign src_addr = src_addr_reg;
  assign obj_addr = obj_addr_reg;
  assign obj_dout = obj_dout_reg;
  assign obj_we   = obj_we_reg;
  assign obj_bank = obj_bank_reg;
  assign dma_busy = dma_busy_reg;

endmodule

// File: tb/tb_jtpopeye_obj_dma.sv
// Testbench for jtpopeye_obj_dma. pxl_cen is active every other clk.
// A scoreboard queue holds the expected object-RAM writes for each frame.
module tb_jtpopeye_obj_dma;

  localparam int          NB   = 160;
  localparam logic [15:0] BASE = 16'h8C04;
  localparam int          TMO  = 255;
`ifdef JTPOPEYE_DBLBUF_EN
  localparam logic DBL = 1'b1;
`else
  localparam logic DBL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pxl_cen;
  logic        VB;
  logic        busrq_n;
  logic        busak_n;
  logic [15:0] src_addr;
  logic [7:0]  src_din;
  logic [8:0]  obj_addr;
  logic [7:0]  obj_dout;
  logic        obj_we;
  logic        obj_bank;
  logic        dma_busy;

  jtpopeye_obj_dma dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .VB       (VB),
    .busrq_n  (busrq_n),
    .busak_n  (busak_n),
    .src_addr (src_addr),
    .src_din  (src_din),
    .obj_addr (obj_addr),
    .obj_dout (obj_dout),
    .obj_we   (obj_we),
    .obj_bank (obj_bank),
    .dma_busy (dma_busy)
  );

  always #5 clk = ~clk;

  logic [7:0] cpu_ram [0:65535];
  logic [7:0] obj_ram [0:511];

  // CPU RAM: data follows the address one pxl_cen tick later
  always @(posedge clk) begin
    if (pxl_cen) src_din <= cpu_ram[src_addr];
  end

  int          checks = 0;
  int          errors = 0;
  int          n_wr   = 0;
  logic        we_prev = 1'b0;
  logic [16:0] exp_q [$];
  logic        bank_exp = 1'b0;
  logic [15:0] src_min, src_max;

  // Scoreboard side: observe each write pulse once and compare against the queue
  task automatic sample();
    logic [16:0] e;
    if (obj_we === 1'b1 && we_prev !== 1'b1) begin
      n_wr++;
      obj_ram[obj_addr] = obj_dout;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%03h data=%02h, expected no write", obj_addr, obj_dout);
      end else begin
        e = exp_q.pop_front();
        if ({obj_addr, obj_dout} !== e) begin
          errors++;
          $display("FAIL write_data: got addr=%03h data=%02h, expected addr=%03h data=%02h",
                   obj_addr, obj_dout, e[16:8], e[7:0]);
        end else begin
          $display("write %0d addr=%03h data=%02h ok", n_wr, obj_addr, obj_dout);
        end
      end
    end
    we_prev = obj_we;
    if (dma_busy === 1'b1) begin
      if (src_addr < src_min) src_min = src_addr;
      if (src_addr > src_max) src_max = src_addr;
    end
  endtask

  // One pxl_cen tick = two clk cycles, inputs driven on the falling edge
  task automatic tick();
    pxl_cen = 1'b1;
    @(negedge clk);
    sample();
    pxl_cen = 1'b0;
    @(negedge clk);
    sample();
  endtask

  task automatic wait_busrq(input logic lvl, input int limit, output int n);
    n = 0;
    while (busrq_n !== lvl && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic push_frame(input logic wb);
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back({wb, 8'(i), 8'(i) ^ 8'h5A});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pxl_cen = 1'b0; VB = 1'b0; busak_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL reset_busrq_n: got %b, expected 1", busrq_n); end
    checks++; if (obj_we !== 1'b0) begin errors++; $display("FAIL reset_obj_we: got %b, expected 0", obj_we); end
    checks++; if (src_addr !== BASE) begin errors++; $display("FAIL reset_src_addr: got %04h, expected %04h", src_addr, BASE); end
    checks++; if (obj_addr !== 9'd0) begin errors++; $display("FAIL reset_obj_addr: got %03h, expected 000", obj_addr); end
    checks++; if (obj_dout !== 8'd0) begin errors++; $display("FAIL reset_obj_dout: got %02h, expected 00", obj_dout); end
    checks++; if (obj_bank !== 1'b0) begin errors++; $display("FAIL reset_obj_bank: got %b, expected 0", obj_bank); end
    checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL reset_dma_busy: got %b, expected 0", dma_busy); end
    rst = 1'b0;
    repeat (3) tick();
    // VB rising with no pxl_cen must not advance anything
    VB = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL no_cen_hold: got busrq_n=%b, expected 1", busrq_n); end
    VB = 1'b0;
    repeat (2) tick();
    $display("reset test done");
  endtask

  task automatic test_nominal(input logic check_other);
    int n, n0, bad;
    logic wb;
    wb = DBL ? ~bank_exp : 1'b0;
    VB = 1'b0; busak_n = 1'b1;
    repeat (3) tick();
    n0 = n_wr;
    src_min = 16'hFFFF; src_max = 16'h0000;
    push_frame(wb);
    VB = 1'b1;
    wait_busrq(1'b0, 8, n);
    checks++; if (n != 1) begin errors++; $display("FAIL req_latency: got %0d ticks, expected 1", n); end
    checks++; if (dma_busy !== 1'b1) begin errors++; $display("FAIL busy_during: got %b, expected 1", dma_busy); end
    repeat (3) tick();
    busak_n = 1'b0;
    wait_busrq(1'b1, 1000, n);
    checks++; if (n != 2 * NB + 2) begin errors++; $display("FAIL frame_ticks: got %0d, expected %0d", n, 2 * NB + 2); end
    busak_n = 1'b1;
    bank_exp = bank_exp ^ DBL;
    checks++; if (n_wr - n0 != NB) begin errors++; $display("FAIL write_count: got %0d, expected %0d", n_wr - n0, NB); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL queue_left: got %0d, expected 0", exp_q.size()); end
    checks++; if (obj_bank !== bank_exp) begin errors++; $display("FAIL bank_after: got %b, expected %b", obj_bank, bank_exp); end
    checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL busy_after: got %b, expected 0", dma_busy); end
    checks++; if (src_min !== BASE || src_max !== BASE + 16'(NB - 1)) begin
      errors++; $display("FAIL src_range: got %04h..%04h, expected %04h..%04h", src_min, src_max, BASE, BASE + 16'(NB - 1));
    end
    bad = 0;
    for (int i = 0; i < NB; i++) begin
      if (obj_ram[{wb, 8'(i)}] !== (8'(i) ^ 8'h5A)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL obj_ram_content: got %0d wrong entries, expected 0", bad); end
    if (check_other) begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (obj_ram[{~wb, 8'(i)}] !== 8'hEE) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL other_bank: got %0d touched entries, expected 0", bad); end
    end
    VB = 1'b0;
    repeat (2) tick();
    $display("nominal frame done, bank=%b", obj_bank);
  endtask

  task automatic test_timeout();
    int n, n0;
    VB = 1'b0; busak_n = 1'b1;
    repeat (3) tick();
    n0 = n_wr;
    VB = 1'b1;
    wait_busrq(1'b0, 8, n);
    checks++; if (n != 1) begin errors++; $display("FAIL tmo_req_latency: got %0d, expected 1", n); end
    wait_busrq(1'b1, 400, n);
    checks++; if (n < TMO || n > TMO + 2) begin errors++; $display("FAIL tmo_release: got %0d ticks, expected %0d..%0d", n, TMO, TMO + 2); end
    checks++; if (n_wr != n0) begin errors++; $display("FAIL tmo_writes: got %0d, expected 0", n_wr - n0); end
    checks++; if (obj_bank !== bank_exp) begin errors++; $display("FAIL tmo_bank: got %b, expected %b", obj_bank, bank_exp); end
    VB = 1'b0;
    repeat (2) tick();
    $display("timeout test done");
  endtask

  // kind 0: VB falls mid-copy; kind 1: CPU drops acknowledge mid-copy
  task automatic test_abort(input int kind, input int stop_at);
    int n, n0, k;
    logic wb;
    wb = DBL ? ~bank_exp : 1'b0;
    VB = 1'b0; busak_n = 1'b1;
    repeat (3) tick();
    n0 = n_wr;
    push_frame(wb);
    VB = 1'b1;
    wait_busrq(1'b0, 8, n);
    repeat (3) tick();
    busak_n = 1'b0;
    k = 0;
    while (n_wr - n0 < stop_at && k < 600) begin tick(); k++; end
    checks++; if (n_wr - n0 != stop_at) begin errors++; $display("FAIL abort%0d_reach: got %0d writes, expected %0d", kind, n_wr - n0, stop_at); end
    if (kind == 0) VB = 1'b0;
    else busak_n = 1'b1;
    wait_busrq(1'b1, 4, n);
    checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL abort%0d_release: got busrq_n=%b after %0d ticks, expected 1", kind, busrq_n, n); end
    busak_n = 1'b1;
    repeat (4) tick();
    checks++; if (n_wr - n0 != stop_at) begin errors++; $display("FAIL abort%0d_writes: got %0d, expected %0d", kind, n_wr - n0, stop_at); end
    checks++; if (exp_q.size() != NB - stop_at) begin errors++; $display("FAIL abort%0d_queue: got %0d, expected %0d", kind, exp_q.size(), NB - stop_at); end
    checks++; if (obj_bank !== bank_exp) begin errors++; $display("FAIL abort%0d_bank: got %b, expected %b", kind, obj_bank, bank_exp); end
    checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL abort%0d_busy: got %b, expected 0", kind, dma_busy); end
    exp_q.delete();
    VB = 1'b0;
    repeat (2) tick();
    $display("abort test %0d done", kind);
  endtask

  task automatic test_reset_mid();
    int n, n0, k;
    logic wb;
    wb = DBL ? ~bank_exp : 1'b0;
    VB = 1'b0; busak_n = 1'b1;
    repeat (3) tick();
    n0 = n_wr;
    push_frame(wb);
    VB = 1'b1;
    wait_busrq(1'b0, 8, n);
    repeat (3) tick();
    busak_n = 1'b0;
    k = 0;
    while (n_wr - n0 < 80 && k < 600) begin tick(); k++; end
    checks++; if (n_wr - n0 != 80) begin errors++; $display("FAIL rstmid_reach: got %0d writes, expected 80", n_wr - n0); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL rstmid_busrq_n: got %b, expected 1", busrq_n); end
    checks++; if (obj_bank !== 1'b0) begin errors++; $display("FAIL rstmid_bank: got %b, expected 0", obj_bank); end
    checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", dma_busy); end
    rst = 1'b0;
    busak_n = 1'b1;
    bank_exp = 1'b0;
    exp_q.delete();
    we_prev = obj_we;
    $display("reset mid-transfer applied, restarting");
    test_nominal(1'b0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) cpu_ram[a] = 8'(a) ^ 8'(a >> 8) ^ 8'hA5;
    for (int i = 0; i < NB; i++) cpu_ram[BASE + 16'(i)] = 8'(i) ^ 8'h5A;
    for (int a = 0; a < 512; a++) obj_ram[a] = 8'hEE;
    test_reset();
    test_nominal(1'b1);
    test_timeout();
    test_abort(0, 50);
    test_abort(1, 20);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
